// File: rtl/sw_debounce_pkg.sv
// Shared types and defaults for the switch debouncer.
package sw_debounce_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 16;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCommit
    } state_e;

endpackage

// File: rtl/sw_sync.sv
// Multi-stage flop synchronizer for asynchronous switch levels, synchronous reset.
module sw_sync #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= i_async;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign o_sync = stage_q[STAGES-1];

endmodule

// File: rtl/sw_debouncer.sv
// Switch-bus debouncer: synchronize, wait for a stable window, commit and raise a
// change event carrying the accumulated mask of changed bits.
module sw_debouncer
    import sw_debounce_pkg::*;
#(
    parameter int unsigned WIDTH           = 32,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_io_sw,
    output logic [WIDTH-1:0] o_sw_data,
    output logic             o_sw_chg_vld,
    input  logic             i_sw_chg_rdy,
    output logic [WIDTH-1:0] o_sw_chg_mask
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             vld_q, vld_d;
    logic             accept;

    sw_sync #(
        .WIDTH  (WIDTH),
        .STAGES (2)
    ) u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (i_io_sw),
        .o_sync  (sync)
    );

    assign accept = vld_q & i_sw_chg_rdy;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= StIdle;
            cand_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        mask_d  = mask_q;
        vld_d   = vld_q;

        if (accept) begin
            vld_d  = 1'b0;
            mask_d = '0;
        end

        unique case (state_q)
            StIdle: begin
                if (sync != data_q) begin
                    cand_d  = sync;
                    cnt_d   = '0;
                    state_d = StSettle;
                end
            end
            StSettle: begin
                // Any movement restarts the stability window on the new value.
                if (sync != cand_q) begin
                    cand_d = sync;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = StCommit;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StCommit: begin
                // A same-cycle accept drops the old bits; only the new diff survives.
                if (cand_q != data_q) begin
                    data_d = cand_q;
                    mask_d = (accept ? '0 : mask_q) | (cand_q ^ data_q);
                    vld_d  = 1'b1;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign o_sw_data     = data_q;
    assign o_sw_chg_vld  = vld_q;
    assign o_sw_chg_mask = mask_q;

endmodule

// File: tb/tb_sw_debouncer.sv
// Directed bench for sw_debouncer with DEBOUNCE_CYCLES=4: vector table plus corner sequences.
module tb_sw_debouncer;

    localparam int unsigned W  = 32;
    localparam int unsigned DC = 4;

    typedef struct {
        logic         reset;
        logic [W-1:0] sw;
        logic         rdy;
        logic [W-1:0] exp_data;
        logic         exp_vld;
        logic [W-1:0] exp_mask;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] sw = '0;
    logic         rdy = 1'b0;
    logic [W-1:0] data;
    logic         vld;
    logic [W-1:0] mask;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    sw_debouncer #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_io_sw       (sw),
        .o_sw_data     (data),
        .o_sw_chg_vld  (vld),
        .i_sw_chg_rdy  (rdy),
        .o_sw_chg_mask (mask)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] ed, input logic ev,
                         input logic [W-1:0] em);
        checks++;
        if (data !== ed || vld !== ev || mask !== em) begin
            errors++;
            $display("FAIL %s: got data=%h vld=%b mask=%h, want data=%h vld=%b mask=%h",
                     name, data, vld, mask, ed, ev, em);
        end
    endtask

    task automatic add(input logic r, input logic [W-1:0] s, input logic y,
                       input logic [W-1:0] ed, input logic ev, input logic [W-1:0] em);
        vec_t v;
        v.reset = r; v.sw = s; v.rdy = y;
        v.exp_data = ed; v.exp_vld = ev; v.exp_mask = em;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        reset = 1'b1; sw = '0; rdy = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int events;
        logic prev_vld;

        // Reset with all switches high, then release: update lands on edge 8.
        for (int i = 0; i < 3; i++) add(1'b1, 32'hFFFF_FFFF, 1'b0, '0, 1'b0, '0);
        for (int i = 1; i < 8; i++) add(1'b0, 32'hFFFF_FFFF, 1'b0, '0, 1'b0, '0);
        add(1'b0, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF);
        add(1'b0, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0, '0);
        add(1'b0, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0, '0);
        // Clean step 0 -> 0xA5.
        for (int i = 0; i < 2; i++) add(1'b1, '0, 1'b0, '0, 1'b0, '0);
        for (int i = 1; i < 8; i++) add(1'b0, 32'hA5, 1'b0, '0, 1'b0, '0);
        add(1'b0, 32'hA5, 1'b0, 32'hA5, 1'b1, 32'hA5);

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].reset;
            sw    = vecs[i].sw;
            rdy   = vecs[i].rdy;
            tick();
            check($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_vld, vecs[i].exp_mask);
        end

        // Event held while rdy=0, then consumed.
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold", 32'hA5, 1'b1, 32'hA5);
        end
        rdy = 1'b1;
        tick();
        check("accept", 32'hA5, 1'b0, '0);
        rdy = 1'b0;

        // Bounce on bit 0, then settle high: exactly one event.
        do_reset();
        events = 0;
        prev_vld = 1'b0;
        for (int i = 0; i < 12; i++) begin
            sw = ((i / 2) % 2 == 0) ? 32'h1 : 32'h0;
            tick();
            check("bounce", '0, 1'b0, '0);
        end
        sw = 32'h1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (vld && !prev_vld) events++;
            prev_vld = vld;
        end
        checks++;
        if (events != 1) begin
            errors++;
            $display("FAIL bounce_events: got %0d, want 1", events);
        end
        check("bounce_final", 32'h1, 1'b1, 32'h1);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;

        // Glitch back to committed value: nothing happens, even with rdy high.
        do_reset();
        rdy = 1'b1;
        sw = 32'h10;
        tick();
        tick();
        sw = '0;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("glitch", '0, 1'b0, '0);
        end
        rdy = 1'b0;

        // Accumulate two commits while rdy=0.
        do_reset();
        sw = 32'h1;
        for (int i = 0; i < 8; i++) tick();
        check("acc_first", 32'h1, 1'b1, 32'h1);
        sw = 32'h3;
        for (int i = 0; i < 7; i++) tick();
        check("acc_pre", 32'h1, 1'b1, 32'h1);
        tick();
        check("acc_or", 32'h3, 1'b1, 32'h3);
        rdy = 1'b1;
        tick();
        check("acc_accept", 32'h3, 1'b0, '0);
        rdy = 1'b0;

        // Accept coinciding with the second commit keeps only the new diff.
        do_reset();
        sw = 32'h1;
        for (int i = 0; i < 8; i++) tick();
        check("coin_first", 32'h1, 1'b1, 32'h1);
        sw = 32'h3;
        for (int i = 0; i < 7; i++) tick();
        rdy = 1'b1;
        tick();
        check("coin_commit", 32'h3, 1'b1, 32'h2);
        rdy = 1'b0;
        tick();
        check("coin_hold", 32'h3, 1'b1, 32'h2);

        // Reset mid-settle with an event pending discards both.
        sw = 32'h7;
        for (int i = 0; i < 4; i++) tick();
        check("mid_pending", 32'h3, 1'b1, 32'h2);
        reset = 1'b1;
        tick();
        check("mid_reset", '0, 1'b0, '0);
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("mid_window", '0, 1'b0, '0);
        end
        tick();
        check("mid_commit", 32'h7, 1'b1, 32'h7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sw_debouncer.md
SW_DEBOUNCER -- requirements
Module: sw_debouncer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the switch bus width.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16, giving the stable cycles required before commit; legal range >= 2.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port i_reset, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port i_io_sw, input, WIDTH, raw asynchronous switch levels from the board.
REQ-006 SHALL have port o_sw_data, output, WIDTH, debounced committed switch value, read by the IO/LSU.
REQ-007 SHALL have port o_sw_chg_vld, output, 1, change event pending.
REQ-008 SHALL have port i_sw_chg_rdy, input, 1, consumer accepts the event.
REQ-009 SHALL have port o_sw_chg_mask, output, WIDTH, OR of bits changed since last accepted event.

Function
REQ-010 SHALL pass i_io_sw through a 2-flop synchronizer; the stage-2 value is "sync".
REQ-011 SHALL implement FSM states IDLE, SETTLE, COMMIT.
REQ-012 IDLE: if sync != o_sw_data, SHALL load candidate<=sync, cnt<=0, go SETTLE; else stay.
REQ-013 SETTLE: if sync != candidate, SHALL reload candidate<=sync and cnt<=0 (restart window); else if cnt==DEBOUNCE_CYCLES-1, go COMMIT; else cnt++.
REQ-014 COMMIT (one cycle): if candidate != o_sw_data, SHALL set o_sw_data<=candidate, o_sw_chg_mask<=mask|(candidate^o_sw_data), o_sw_chg_vld<=1; always return to IDLE.
REQ-015 A glitch settling back to the committed value SHALL produce no event and no o_sw_data change.
REQ-016 For a clean raw step held stable, o_sw_data SHALL update exactly DEBOUNCE_CYCLES+4 rising edges after the first edge sampling the new value.
REQ-017 cnt width SHALL be $clog2(DEBOUNCE_CYCLES)+1; cnt never exceeds DEBOUNCE_CYCLES-1.
REQ-018 Handshake: event transfers when o_sw_chg_vld && i_sw_chg_rdy at a rising edge; vld and mask then clear next cycle.
REQ-019 vld and mask SHALL hold stable while vld=1 and rdy=0, except that a further commit ORs new bits into mask.
REQ-020 On accept in the same cycle as a commit with change, SHALL set mask<=only the new diff and keep vld=1.
REQ-021 i_sw_chg_rdy while vld=0 SHALL have no effect.

Reset
REQ-022 While i_reset=1 at a rising edge, SHALL clear the sync flops, candidate, cnt, o_sw_data, o_sw_chg_mask and o_sw_chg_vld to 0, and force state to IDLE.
REQ-023 Reset mid-SETTLE or with an event pending SHALL discard the window and event; no event emitted for pre-reset activity.
REQ-024 After reset release with nonzero switches, the normal IDLE->SETTLE->COMMIT path SHALL report them as a change from 0.

Structure
REQ-025 SHALL place the FSM state enum typedef and the DEBOUNCE_CYCLES default constant in shared package sw_debounce_pkg.
REQ-026 SHALL instantiate the synchronizer as sub-module sw_sync (parameterized WIDTH, 2 stages, synchronous reset).

Verification (DEBOUNCE_CYCLES=4)
REQ-027 Reset: i_io_sw=0xFFFF_FFFF during reset -> all outputs 0; after release, o_sw_data=0xFFFF_FFFF at edge 8, vld=1, mask=0xFFFF_FFFF.
REQ-028 Clean step 0->0x0000_00A5, rdy=0 -> o_sw_data=0xA5 at edge 8; vld/mask=0xA5 held 20 cycles; rdy pulse -> cleared next cycle.
REQ-029 Bounce: bit0 toggles every 2 cycles for 12 cycles then holds 1 -> o_sw_data unchanged during bounce; exactly one event, mask=0x1.
REQ-030 Glitch: 0x0->0x10 for 2 cycles ->0x0 -> no event; o_sw_data stays 0.
REQ-031 Accumulate: commit 0x1 then 0x3 with rdy=0 -> mask=0x3, vld=1; a second run with rdy=1 in the 2nd commit cycle -> mask=0x2, vld stays 1.
REQ-032 Reset asserted mid-SETTLE with an event pending -> all cleared; no event until a fresh stable window completes.
